// File: rtl/ibus_arbiter_if.sv
// Signal bundle between fetch/commit, the instruction-bus arbiter and the MMU port.
// The arbiter masters the instruction bus, so it takes the master modport.
interface ibus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OP_W   = 2
) ();
  // Fetch side
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_grant;
  logic              f_data_ok;
  logic [DATA_W-1:0] f_data;
  // Commit cache-op side
  logic              c_req;
  logic [ADDR_W-1:0] c_addr;
  logic [OP_W-1:0]   c_op;
  logic              c_done;
  // Pipeline control / status
  logic              flush;
  logic              busy;
  // MMU instruction port
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic [OP_W-1:0]   m_op;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  f_req, f_addr, c_req, c_addr, c_op, flush, m_addr_ok, m_data_ok, m_data,
    output f_grant, f_data_ok, f_data, c_done, busy, m_req, m_addr, m_op
  );

  modport slave (
    output f_req, f_addr, c_req, c_addr, c_op, flush, m_addr_ok, m_data_ok, m_data,
    input  f_grant, f_data_ok, f_data, c_done, busy, m_req, m_addr, m_op
  );
endinterface

// File: rtl/ibus_arbiter.sv
// Arbitrates the single instruction bus between fetch and commit cache ops, one
// transaction at a time, and drops fetch responses that a flush made stale.
module ibus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OP_W   = 2
) (
  input logic           clk,
  input logic           reset,
  ibus_arbiter_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] F_ADDR = 3'd1;
  localparam logic [2:0] F_DATA = 3'd2;
  localparam logic [2:0] C_ADDR = 3'd3;
  localparam logic [2:0] C_DATA = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              kill_q, kill_d;
  logic              kill_now;
  logic              grant;
  logic              fetch_ok;
  logic              done;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    op_d     = op_q;
    kill_d   = kill_q;
    kill_now = kill_q | bus.flush;
    grant    = 1'b0;
    fetch_ok = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        // Commit wins; a flush in the same cycle only blocks the fetch.
        if (bus.c_req) begin
          addr_d  = bus.c_addr;
          op_d    = bus.c_op;
          state_d = C_ADDR;
        end else if (bus.f_req && !bus.flush) begin
          addr_d  = bus.f_addr;
          op_d    = '0;
          state_d = F_ADDR;
        end
      end
      F_ADDR: begin
        // The request is never withdrawn; a flush only marks the fetch as dead.
        kill_d = kill_now;
        if (bus.m_addr_ok) begin
          grant   = ~kill_now;
          state_d = F_DATA;
        end
      end
      F_DATA: begin
        kill_d = kill_now;
        if (bus.m_data_ok) begin
          fetch_ok = ~kill_now;
          kill_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      C_ADDR: begin
        if (bus.m_addr_ok) begin
          state_d = C_DATA;
        end
      end
      C_DATA: begin
        if (bus.m_data_ok) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      kill_q  <= kill_d;
    end
  end

  assign bus.m_req     = (state_q == F_ADDR) || (state_q == C_ADDR);
  assign bus.m_addr    = addr_q;
  assign bus.m_op      = op_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.f_grant   = grant;
  assign bus.f_data_ok = fetch_ok;
  assign bus.c_done    = done;
  // Data is gated so f_data reads zero whenever no fetch response is delivered.
  assign bus.f_data    = fetch_ok ? bus.m_data : '0;

endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed bench for ibus_arbiter: a bus-side responder with a scoreboard of
// expected bus requests and expected fetch data.
module tb_ibus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned OP_W   = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OP_W-1:0]   op;
  } bus_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bus_t              exp_bus[$];
  logic [DATA_W-1:0] exp_data[$];

  ibus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W)) bif ();

  ibus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the X_ADDR phase: n_wait cycles without addr_ok, then the accept cycle.
  task automatic addr_phase(input int n_wait, input logic exp_grant, input logic with_data);
    bus_t e;
    chk1("bus_q_nonempty", exp_bus.size() != 0, 1'b1);
    e = (exp_bus.size() != 0) ? exp_bus[0] : '0;
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clk);
      chk1("addr_wait_m_req", bif.m_req, 1'b1);
      chk64("addr_wait_m_addr", 64'(bif.m_addr), 64'(e.addr));
      chk1("addr_wait_f_grant", bif.f_grant, 1'b0);
      chk1("addr_wait_busy", bif.busy, 1'b1);
      tick();
    end
    bif.m_addr_ok = 1'b1;
    if (with_data) begin
      bif.m_data_ok = 1'b1;
      bif.m_data    = 64'hFFFF_0000_FFFF_0000;
    end
    @(negedge clk);
    if (exp_bus.size() != 0) e = exp_bus.pop_front();
    chk1("addr_ok_m_req", bif.m_req, 1'b1);
    chk64("addr_ok_m_addr", 64'(bif.m_addr), 64'(e.addr));
    chk64("addr_ok_m_op", 64'(bif.m_op), 64'(e.op));
    chk1("addr_ok_f_grant", bif.f_grant, exp_grant);
    chk1("addr_ok_c_done", bif.c_done, 1'b0);
    chk1("addr_ok_f_data_ok", bif.f_data_ok, 1'b0);
    tick();
    bif.m_addr_ok = 1'b0;
    bif.m_data_ok = 1'b0;
    bif.m_data    = '0;
  endtask

  // kind: 0 = live fetch, 1 = killed fetch, 2 = commit op.
  task automatic data_phase(input int n_wait, input logic [DATA_W-1:0] data, input int kind);
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clk);
      chk1("data_wait_m_req", bif.m_req, 1'b0);
      chk1("data_wait_busy", bif.busy, 1'b1);
      chk1("data_wait_f_data_ok", bif.f_data_ok, 1'b0);
      chk1("data_wait_c_done", bif.c_done, 1'b0);
      chk1("data_wait_f_grant", bif.f_grant, 1'b0);
      tick();
    end
    bif.m_data_ok = 1'b1;
    bif.m_data    = data;
    if (kind == 0) exp_data.push_back(data);
    if (kind == 2) bif.c_req = 1'b0;
    @(negedge clk);
    if (kind == 0) begin
      chk1("fetch_data_ok", bif.f_data_ok, 1'b1);
      chk1("fetch_q_nonempty", exp_data.size() != 0, 1'b1);
      if (exp_data.size() != 0) chk64("fetch_data", bif.f_data, exp_data.pop_front());
    end else if (kind == 1) begin
      chk1("killed_f_data_ok", bif.f_data_ok, 1'b0);
    end else begin
      chk1("commit_c_done", bif.c_done, 1'b1);
      chk1("commit_f_data_ok", bif.f_data_ok, 1'b0);
    end
    tick();
    bif.m_data_ok = 1'b0;
    bif.m_data    = '0;
    @(negedge clk);
    chk1("idle_busy", bif.busy, 1'b0);
    chk1("idle_m_req", bif.m_req, 1'b0);
    chk1("idle_c_done", bif.c_done, 1'b0);
    chk1("idle_f_data_ok", bif.f_data_ok, 1'b0);
  endtask

  task automatic issue_fetch(input logic [ADDR_W-1:0] addr);
    bif.f_req  = 1'b1;
    bif.f_addr = addr;
    exp_bus.push_back('{addr: addr, op: '0});
    tick();
    bif.f_req = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bif.f_req     = 1'b0;
    bif.f_addr    = '0;
    bif.c_req     = 1'b0;
    bif.c_addr    = '0;
    bif.c_op      = '0;
    bif.flush     = 1'b0;
    bif.m_addr_ok = 1'b0;
    bif.m_data_ok = 1'b0;
    bif.m_data    = '0;

    // Reset state
    @(negedge clk);
    chk1("rst_m_req", bif.m_req, 1'b0);
    chk64("rst_m_addr", 64'(bif.m_addr), 64'd0);
    chk64("rst_m_op", 64'(bif.m_op), 64'd0);
    chk1("rst_busy", bif.busy, 1'b0);
    chk1("rst_f_grant", bif.f_grant, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // Fetch only: addr_ok on second m_req cycle, data_ok three cycles later
    bif.f_req  = 1'b1;
    bif.f_addr = 32'hBFC0_0000;
    exp_bus.push_back('{addr: 32'hBFC0_0000, op: 2'd0});
    @(negedge clk);
    chk1("arb_latency_m_req", bif.m_req, 1'b0);
    tick();
    bif.f_req = 1'b0;
    addr_phase(1, 1'b1, 1'b0);
    data_phase(2, 64'h1234_5678_9ABC_DEF0, 0);

    // Commit and fetch together: commit first, then fetch
    bif.c_req  = 1'b1;
    bif.c_addr = 32'h8000_1000;
    bif.c_op   = 2'd2;
    bif.f_req  = 1'b1;
    bif.f_addr = 32'h0040_0000;
    exp_bus.push_back('{addr: 32'h8000_1000, op: 2'd2});
    exp_bus.push_back('{addr: 32'h0040_0000, op: 2'd0});
    tick();
    addr_phase(1, 1'b0, 1'b0);
    data_phase(2, 64'h0, 2);
    tick();
    bif.f_req = 1'b0;
    addr_phase(0, 1'b1, 1'b0);
    data_phase(0, 64'hCAFE_F00D_0000_0001, 0);

    // Flush in F_DATA one cycle before data_ok, then a normal fetch
    issue_fetch(32'h0000_1000);
    addr_phase(0, 1'b1, 1'b0);
    bif.flush = 1'b1;
    @(negedge clk);
    chk1("flush_fdata_busy", bif.busy, 1'b1);
    tick();
    bif.flush = 1'b0;
    data_phase(0, 64'h1111_2222_3333_4444, 1);
    issue_fetch(32'h0000_2000);
    addr_phase(1, 1'b1, 1'b0);
    data_phase(1, 64'h5555_6666_7777_8888, 0);

    // Flush in IDLE drops the fetch for that cycle only
    bif.f_req  = 1'b1;
    bif.f_addr = 32'h0000_3000;
    bif.flush  = 1'b1;
    tick();
    bif.flush = 1'b0;
    @(negedge clk);
    chk1("flush_idle_busy", bif.busy, 1'b0);
    chk1("flush_idle_m_req", bif.m_req, 1'b0);
    // Same f_req now issues, then a flush in F_ADDR with addr_ok four cycles late
    exp_bus.push_back('{addr: 32'h0000_3000, op: 2'd0});
    tick();
    bif.f_req = 1'b0;
    bif.flush = 1'b1;
    @(negedge clk);
    chk1("flush_faddr_m_req", bif.m_req, 1'b1);
    chk1("flush_faddr_f_grant", bif.f_grant, 1'b0);
    tick();
    bif.flush = 1'b0;
    addr_phase(3, 1'b0, 1'b0);
    data_phase(2, 64'h9999_AAAA_BBBB_CCCC, 1);

    // Async reset in F_DATA, then a stray data_ok after release
    issue_fetch(32'h0000_4000);
    addr_phase(0, 1'b1, 1'b0);
    #2;
    chk1("pre_rst_busy", bif.busy, 1'b1);
    reset         = 1'b0;
    bif.m_data_ok = 1'b1;
    bif.m_data    = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk1("async_rst_busy", bif.busy, 1'b0);
    chk1("async_rst_m_req", bif.m_req, 1'b0);
    chk1("async_rst_f_data_ok", bif.f_data_ok, 1'b0);
    chk64("async_rst_f_data", bif.f_data, 64'd0);
    chk64("async_rst_m_addr", 64'(bif.m_addr), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk1("stray_f_data_ok", bif.f_data_ok, 1'b0);
    chk1("stray_busy", bif.busy, 1'b0);
    tick();
    bif.m_data_ok = 1'b0;
    bif.m_data    = '0;

    // addr_ok and data_ok together in C_ADDR count as addr_ok only
    bif.c_req  = 1'b1;
    bif.c_addr = 32'h8000_2000;
    bif.c_op   = 2'd1;
    exp_bus.push_back('{addr: 32'h8000_2000, op: 2'd1});
    tick();
    addr_phase(0, 1'b0, 1'b1);
    data_phase(1, 64'h0, 2);

    chk1("bus_q_drained", exp_bus.size() == 0, 1'b1);
    chk1("data_q_drained", exp_data.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibus_arbiter.md
Name: ibus_arbiter

Overview:
- Shares the single instruction bus (I-cache/MMU side) between two requesters: the fetch stage (F) and commit-stage I-cache maintenance ops (C).
- Serialises them with at most one outstanding transaction, and sequences address/data handshakes.
- Discards stale fetch responses after a pipeline flush.
- Sits between fetch/commit and the MMU instruction port.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 64, response data width (two instructions)
- OP_W, 2, cache-op code width (0 = normal fetch)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- f_req  in  1  fetch request valid
- f_addr  in  ADDR_W  fetch address
- f_grant  out  1  fetch address accepted this cycle
- f_data_ok  out  1  fetch data valid, one-cycle pulse
- f_data  out  DATA_W  fetch data
- c_req  in  1  commit cache-op request valid
- c_addr  in  ADDR_W  cache-op address
- c_op  in  OP_W  cache-op code, nonzero
- c_done  out  1  cache op completed, one-cycle pulse
- flush  in  1  pipeline flush, kills pending or outstanding fetch
- busy  out  1  transaction outstanding (state != IDLE)
- m_req  out  1  bus request valid
- m_addr  out  ADDR_W  bus address
- m_op  out  OP_W  bus op code
- m_addr_ok  in  1  bus accepted address
- m_data_ok  in  1  bus returned data/completion
- m_data  in  DATA_W  bus data

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; m_addr=0, m_op=0; kill flag cleared. A transaction in flight at reset is abandoned; any m_data_ok arriving after reset release while IDLE is ignored.
- States:
  - IDLE
  - F_ADDR: m_req high, waiting m_addr_ok, fetch
  - F_DATA: waiting m_data_ok, fetch
  - C_ADDR
  - C_DATA
- IDLE arbitration is combinational in the same cycle:
  - c_req has priority over f_req.
  - Winner's addr/op are latched into registers; m_addr/m_op are driven from the registers.
  - Next state is C_ADDR or F_ADDR.
  - Fetch uses m_op=0.
- X_ADDR:
  - m_req=1 with registered addr/op, held stable until m_addr_ok.
  - On m_addr_ok: m_req drops the next cycle; state goes to X_DATA. For fetch, f_grant pulses 1 in that same m_addr_ok cycle.
- X_DATA:
  - m_req=0.
  - On m_data_ok: state goes to IDLE.
  - Fetch: f_data_ok=1 and f_data=m_data in the same cycle (combinational pass-through), unless killed.
  - Commit: c_done=1 in that cycle.
- Latency: request to grant is at least 1 cycle (IDLE→X_ADDR registered). No back-to-back issue: a new arbitration only happens after returning to IDLE.
- Flush:
  - In IDLE: nothing latched; f_req is ignored that cycle.
  - In F_ADDR: m_req stays high until m_addr_ok (a request is never withdrawn), then goes to F_DATA with kill=1. f_grant is suppressed when killed.
  - In F_DATA: kill=1.
  - Killed response: m_data_ok returns to IDLE with f_data_ok=0.
  - flush has no effect on C_* states.
- Simultaneous events:
  - m_addr_ok and m_data_ok in the same cycle in X_ADDR: treated as addr_ok only. The bus guarantees data_ok comes at least 1 cycle after addr_ok.
  - flush in the same cycle as m_data_ok in F_DATA: response discarded.
- busy=1 in every state except IDLE.
- c_req must remain asserted until c_done. The arbiter does not re-sample it after latching.

Test Plan:
- Fetch only: f_req=1, f_addr=0xBFC00000; bus gives addr_ok 2 cycles later, data_ok 3 cycles after that with 0x1234_5678_9ABC_DEF0 -> m_req high 2 cycles with m_addr=0xBFC00000, m_op=0; one f_grant pulse; f_data_ok pulse with the exact data; return to IDLE.
- Both request in IDLE: c_req (addr 0x80001000, op=2) and f_req together -> commit issued first with m_op=2; c_done on data_ok; fetch issued next with m_op=0.
- Flush in F_DATA: flush=1 one cycle before m_data_ok -> f_data_ok stays 0; busy falls after data_ok; next f_req issues normally.
- Flush in F_ADDR with addr_ok delayed 4 cycles -> m_req held with a stable address throughout; f_grant=0; data later dropped.
- Async reset asserted mid F_DATA -> outputs 0 immediately without clk; after release, a stray m_data_ok produces no f_data_ok.
- addr_ok and data_ok asserted together in C_ADDR -> moves to C_DATA; c_done only on the next data_ok.
